hyperbola_sqrt_iter_ctrl: RTL and testbench

- Iterative sequencer for the hyperbolic radix-4 CORDIC sqrt path.
- Owns one shared radix-4 rotation stage, which has a fixed 3-cycle latency and advances rotation by 1..5 per pass.
- Accepts one (X,Y) job at a time, loops it through the stage until the rotation index reaches MAX_ROTT, then presents the final X, Y and the accumulated gain K.
- Sits between the sqrt front-end (operand pre-scaling) and the K-compensation multiplier.

---
 rtl/sqrt_cordic_pkg.sv | 19 +
 rtl/hyperbola_sqrt_iter_ctrl.sv | 156 +++++++++++++++
 tb/tb_hyperbola_sqrt_iter_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_cordic_pkg.sv
// Shared types and constants for the hyperbolic radix-4 CORDIC sqrt path.
// State encoding, rotation width, unity gain and default stage timing.
package sqrt_cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int ROTT_W       = 6;
  localparam int ITER_W       = 5;
  localparam int DEF_DSIZE    = 17;
  localparam int K_ONE        = 2 ** (DEF_DSIZE - 1);
  localparam int DEF_STG_LAT  = 3;
  localparam int DEF_MAX_ROTT = 16;

endpackage

// File: rtl/hyperbola_sqrt_iter_ctrl.sv
// Iterative sequencer: loops one (X,Y) job through a shared radix-4
// rotation stage until the rotation index reaches MAX_ROTT, then holds
// the final X, Y and gain K until the consumer accepts them.
// Ports: clock/rst (sync, active-high); in_valid/in_ready + in_x/in_y
// job input; stg_* drive and sample the rotation stage; out_valid/
// out_ready + out_x/out_y/out_k/out_iters/out_timeout result.
module hyperbola_sqrt_iter_ctrl
  import sqrt_cordic_pkg::*;
#(
  parameter int DSIZE      = DEF_DSIZE,
  parameter int STG_LAT    = DEF_STG_LAT,
  parameter int START_ROTT = 1,
  parameter int MAX_ROTT   = DEF_MAX_ROTT,
  parameter int MAX_ITER   = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DSIZE-1:0]  in_x,
  input  logic [DSIZE-1:0]  in_y,
  output logic [DSIZE-1:0]  stg_ix,
  output logic [DSIZE-1:0]  stg_iy,
  output logic [ROTT_W-1:0] stg_rott,
  output logic [DSIZE-1:0]  stg_k,
  input  logic [DSIZE-1:0]  stg_ox,
  input  logic [DSIZE-1:0]  stg_oy,
  input  logic [ROTT_W-1:0] stg_next_rott,
  input  logic [DSIZE-1:0]  stg_next_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  out_x,
  output logic [DSIZE-1:0]  out_y,
  output logic [DSIZE-1:0]  out_k,
  output logic [ITER_W-1:0] out_iters,
  output logic              out_timeout
);

  if (MAX_ITER < 1 || MAX_ITER > 31) begin : g_bad_iter
    $error("MAX_ITER must be in 1..31");
  end
  if (STG_LAT < 1) begin : g_bad_lat
    $error("STG_LAT must be at least 1");
  end

  localparam int CW = (STG_LAT > 1) ? $clog2(STG_LAT) : 1;
  localparam logic [CW-1:0]     LAST  = CW'(STG_LAT - 1);
  localparam logic [ROTT_W-1:0] R0    = ROTT_W'(START_ROTT);
  localparam logic [ROTT_W-1:0] RMAX  = ROTT_W'(MAX_ROTT);
  localparam logic [ITER_W-1:0] IMAX  = ITER_W'(MAX_ITER);
  localparam logic [DSIZE-1:0]  KONE  = {1'b1, {(DSIZE-1){1'b0}}};

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [ITER_W-1:0] iter, iter_nx;

  logic [DSIZE-1:0]  ix_nx, iy_nx, k_nx;
  logic [ROTT_W-1:0] rott_nx;
  logic [DSIZE-1:0]  ox_nx, oy_nx, ok_nx;
  logic [ITER_W-1:0] oit_nx;
  logic              oto_nx;
  logic              rott_done;

  // Unsigned compare: any index past MAX_ROTT also ends the job.
  assign rott_done = (stg_next_rott >= RMAX);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    iter_nx  = iter;
    ix_nx    = stg_ix;
    iy_nx    = stg_iy;
    rott_nx  = stg_rott;
    k_nx     = stg_k;
    ox_nx    = out_x;
    oy_nx    = out_y;
    ok_nx    = out_k;
    oit_nx   = out_iters;
    oto_nx   = out_timeout;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          ix_nx    = in_x;
          iy_nx    = in_y;
          rott_nx  = R0;
          k_nx     = KONE;
          iter_nx  = '0;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_nx   = '0;
        iter_nx  = iter + 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == LAST) begin
          if (rott_done || iter == IMAX) begin
            ox_nx    = stg_ox;
            oy_nx    = stg_oy;
            ok_nx    = stg_next_k;
            oit_nx   = iter;
            oto_nx   = !rott_done;
            state_nx = S_DONE;
          end else begin
            ix_nx    = stg_ox;
            iy_nx    = stg_oy;
            rott_nx  = stg_next_rott;
            k_nx     = stg_next_k;
            state_nx = S_ISSUE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      iter        <= '0;
      stg_ix      <= '0;
      stg_iy      <= '0;
      stg_rott    <= R0;
      stg_k       <= KONE;
      out_x       <= '0;
      out_y       <= '0;
      out_k       <= '0;
      out_iters   <= '0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      iter        <= iter_nx;
      stg_ix      <= ix_nx;
      stg_iy      <= iy_nx;
      stg_rott    <= rott_nx;
      stg_k       <= k_nx;
      out_x       <= ox_nx;
      out_y       <= oy_nx;
      out_k       <= ok_nx;
      out_iters   <= oit_nx;
      out_timeout <= oto_nx;
    end
  end

endmodule

// File: tb/tb_hyperbola_sqrt_iter_ctrl.sv
// Directed scoreboard bench for hyperbola_sqrt_iter_ctrl with a
// 3-cycle pipelined behavioural rotation stage.
module tb_hyperbola_sqrt_iter_ctrl;
  import sqrt_cordic_pkg::*;

  localparam int DW = 17;
  localparam logic [DW-1:0] GAIN = 17'h10800;
  localparam logic [DW-1:0] KONE = 17'h10000;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [5:0]    r;
    logic [DW-1:0] k;
  } stg_t;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] k;
    logic [4:0]    it;
    logic          to;
  } res_t;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic in_ready, out_valid, out_timeout;
  logic [DW-1:0] stg_ix, stg_iy, stg_k, stg_ox, stg_oy, stg_next_k;
  logic [5:0] stg_rott, stg_next_rott;
  logic [DW-1:0] out_x, out_y, out_k;
  logic [4:0] out_iters;

  int total = 0;
  int bad = 0;
  int mode = 0;
  res_t sb[$];
  stg_t ein[32];
  int npass;
  stg_t p0, p1, p2;

  hyperbola_sqrt_iter_ctrl dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y),
    .stg_ix(stg_ix), .stg_iy(stg_iy),
    .stg_rott(stg_rott), .stg_k(stg_k),
    .stg_ox(stg_ox), .stg_oy(stg_oy),
    .stg_next_rott(stg_next_rott), .stg_next_k(stg_next_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_k(out_k),
    .out_iters(out_iters), .out_timeout(out_timeout)
  );

  always #5 clock = ~clock;

  function automatic stg_t model(input stg_t i, input int md);
    stg_t o;
    logic [33:0] pr;
    pr = 34'(i.k) * 34'(GAIN);
    o.x = i.x + 17'(i.r) + 17'd3;
    o.y = i.y - 17'd7;
    o.k = pr[32:16];
    case (md)
      0: o.r = i.r + 6'd5;
      1: o.r = i.r + 6'd1;
      2: o.r = i.r;
      default: o.r = 6'd63;
    endcase
    return o;
  endfunction

  always @(posedge clock) begin
    p0 <= model({stg_ix, stg_iy, stg_rott, stg_k}, mode);
    p1 <= p0;
    p2 <= p1;
  end

  assign stg_ox        = p2.x;
  assign stg_oy        = p2.y;
  assign stg_next_rott = p2.r;
  assign stg_next_k    = p2.k;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic plan(input logic [DW-1:0] x, input logic [DW-1:0] y);
    stg_t o;
    res_t r;
    int p;
    ein[0] = {x, y, 6'd1, KONE};
    p = 1;
    forever begin
      o = model(ein[p-1], mode);
      if (o.r >= 6'd16 || p == 16) begin
        r = {o.x, o.y, o.k, 5'(p), (o.r < 6'd16)};
        break;
      end
      ein[p] = o;
      p++;
    end
    npass = p;
    sb.push_back(r);
  endtask

  task automatic run_job(input logic [DW-1:0] x, input logic [DW-1:0] y);
    stg_t save, cur;
    plan(x, y);
    chk("idle_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    @(negedge clock);
    in_valid = 1'b0;
    for (int p = 0; p < npass; p++) begin
      save = {stg_ix, stg_iy, stg_rott, stg_k};
      chk("stg_in", 64'(save), 64'(ein[p]));
      for (int w = 0; w < 3; w++) begin
        @(negedge clock);
        cur = {stg_ix, stg_iy, stg_rott, stg_k};
        chk("stg_hold", 64'(cur), 64'(save));
        chk("busy_rdy", 64'({in_ready, out_valid}), 64'd0);
      end
      @(negedge clock);
    end
    chk("done_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input int hold);
    res_t e, got;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty obs=0 exp=1");
      return;
    end
    e = sb.pop_front();
    got = {out_x, out_y, out_k, out_iters, out_timeout};
    chk("result", 64'(got), 64'(e));
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_x = 17'(c * 97 + 5);
      @(negedge clock);
      got = {out_x, out_y, out_k, out_iters, out_timeout};
      chk("bp_stable", 64'(got), 64'(e));
      chk("bp_flags", 64'({in_ready, out_valid}), 64'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("release", 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    chk("rst_flags", 64'({in_ready, out_valid}), 64'b10);
    chk("rst_out", 64'({out_x, out_y, out_k, out_iters, out_timeout}),
        64'd0);
    chk("rst_stg", 64'({stg_ix, stg_iy, stg_rott, stg_k}),
        64'({17'd0, 17'd0, 6'd1, KONE}));

    mode = 0;
    run_job(17'd100, 17'h1ffec);
    drain(0);

    mode = 1;
    run_job(17'd4321, 17'd250);
    drain(0);

    mode = 2;
    run_job(17'd77, 17'h1f000);
    drain(10);

    mode = 3;
    run_job(17'd9, 17'd11);
    drain(0);

    mode = 1;
    plan(17'd500, 17'd600);
    void'(sb.pop_back());
    in_valid = 1'b1;
    in_x = 17'd500;
    in_y = 17'd600;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    chk("mid_rst_flags", 64'({in_ready, out_valid}), 64'b10);
    chk("mid_rst_stg", 64'({stg_ix, stg_iy, stg_rott, stg_k}),
        64'({17'd0, 17'd0, 6'd1, KONE}));
    chk("mid_rst_out", 64'({out_x, out_y, out_k, out_iters, out_timeout}),
        64'd0);

    mode = 0;
    run_job(17'd31, 17'd2);
    drain(0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
